// File: rtl/dmem_sized_ctrl_pkg.sv
// dmem_sized_ctrl_pkg: funct3 codes, FSM states and access helpers for the data memory
package dmem_sized_ctrl_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    function automatic logic [2:0] access_bytes(input logic [2:0] f3);
        return f3[1] ? 3'd4 : f3[0] ? 3'd2 : 3'd1;
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        return (f3 inside {F3_B, F3_H, F3_W}) || (!we && (f3 inside {F3_BU, F3_HU}));
    endfunction
endpackage

// File: rtl/dmem_sized_ctrl_lane_align.sv
// dmem_sized_ctrl_lane_align: byte-lane strobes, store data placement and load extension
module dmem_sized_ctrl_lane_align
    import dmem_sized_ctrl_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  strb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);
    logic [31:0] lane;

    // Move the addressed lane to bit 0 for loads, move store data up to its lane
    always_comb begin
        lane       = rword_i >> {off_i, 3'b000};
        wdata_o    = wdata_i << {off_i, 3'b000};
        strb_o     = funct3_i[1] ? 4'b1111 : funct3_i[0] ? 4'b0011 << off_i : 4'b0001 << off_i;
        rdata_o    = funct3_i == F3_B  ? {{24{lane[7]}}, lane[7:0]} :
                     funct3_i == F3_H  ? {{16{lane[15]}}, lane[15:0]} :
                     funct3_i == F3_BU ? {24'b0, lane[7:0]} :
                     funct3_i == F3_HU ? {16'b0, lane[15:0]} : lane;
        misalign_o = funct3_i[1] ? off_i != 2'b00 : funct3_i[0] & off_i[0];
    end
endmodule

// File: rtl/dmem_sized_ctrl.sv
// dmem_sized_ctrl: RV32I sized-access data memory with valid/ready handshake and wait states
module dmem_sized_ctrl
    import dmem_sized_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int DW = DEPTH_BYTES / 4;
    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic [31:0]           mem [DW];

    logic                  hs, commit, cur_we, misalign, oor, err;
    logic [2:0]            cur_f3;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [31:0]           cur_wdata, wdata_sh, rdata_ext;
    logic [ADDR_WIDTH:0]   end_addr;
    logic [3:0]            strb;

    assign req_ready = state_q == S_IDLE && !rst;
    assign hs        = req_valid && req_ready;
    assign rsp_valid = state_q == S_RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // With no wait states the commit edge is the handshake edge, so take the live request
    assign cur_we    = state_q == S_IDLE ? req_we     : we_q;
    assign cur_f3    = state_q == S_IDLE ? req_funct3 : f3_q;
    assign cur_addr  = state_q == S_IDLE ? req_addr   : addr_q;
    assign cur_wdata = state_q == S_IDLE ? req_wdata  : wdata_q;

    assign end_addr = {1'b0, cur_addr} + (ADDR_WIDTH + 1)'(access_bytes(cur_f3));
    assign oor      = end_addr > (ADDR_WIDTH + 1)'(DEPTH_BYTES);
    assign err      = !f3_legal(cur_we, cur_f3) || misalign || oor;
    assign commit   = !rst && state_d == S_RESP && state_q != S_RESP;

    dmem_sized_ctrl_lane_align u_align (
        .funct3_i   (cur_f3),
        .off_i      (cur_addr[1:0]),
        .wdata_i    (cur_wdata),
        .rword_i    (mem[cur_addr[AW-1:2]]),
        .strb_o     (strb),
        .wdata_o    (wdata_sh),
        .rdata_o    (rdata_ext),
        .misalign_o (misalign)
    );

    // Next-state: IDLE -> (ACCESS) -> RESP -> IDLE, no bypass from RESP
    always_comb begin
        state_d = state_q;
        state_d = state_q == S_IDLE   ? (hs ? (WAIT_STATES > 0 ? S_ACCESS : S_RESP) : S_IDLE) :
                  state_q == S_ACCESS ? (cnt_q == WS_LAST ? S_RESP : S_ACCESS) :
                                        (rsp_ready ? S_IDLE : S_RESP);
    end

    // State register and wait-state counter
    always_ff @(posedge clk) begin
        state_q <= rst ? S_IDLE : state_d;
        cnt_q   <= rst || state_q != S_ACCESS ? 4'd0 : cnt_q + 4'd1;
    end

    // Request latch, only loaded on handshake so later input changes are ignored
    always_ff @(posedge clk) begin
        if (hs) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Response registers, captured on the edge entering RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (commit) begin
            rdata_q <= cur_we || err ? 32'd0 : rdata_ext;
            err_q   <= err;
        end
    end

    // Byte-lane writes of legal stores; contents survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (commit && cur_we && !err && strb[i])
                mem[cur_addr[AW-1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_sized_ctrl.sv
// tb_dmem_sized_ctrl: directed vector and sequence checks for zero and three wait states
module tb_dmem_sized_ctrl;
    import dmem_sized_ctrl_pkg::*;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_sized_ctrl #(.ADDR_WIDTH(32), .DEPTH_BYTES(1024), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_sized_ctrl #(.ADDR_WIDTH(32), .DEPTH_BYTES(1024), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction on DUT d; called and returns 1 time unit after a rising edge
    task automatic op(input int d, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int n;
        rsp_ready[d] = 1'b1;
        req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3; req_addr[d] = addr; req_wdata[d] = wd;
        n = 0;
        while (!req_ready[d] && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        n = 0;
        while (!rsp_valid[d] && n < 40) begin @(posedge clk); #1; n++; end
        if (!rsp_valid[d]) begin
            checks++; errors++;
            $display("FAIL op timeout dut%0d addr %h: rsp_valid got 0 expected 1", d, addr);
        end
        rd = rsp_rdata[d]; er = rsp_err[d];
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        v [$];
        logic [31:0] rd;
        logic        er;
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_exp [3];

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 0; req_we[d] = 0; req_funct3[d] = 0; req_addr[d] = 0; req_wdata[d] = 0;
            rsp_ready[d] = 1;
        end

        v.push_back('{1'b1, F3_W,  32'h010, 32'hDEADBEEF, 32'h0,        1'b0});
        v.push_back('{1'b0, F3_W,  32'h010, 32'h0,        32'hDEADBEEF, 1'b0});
        v.push_back('{1'b0, F3_BU, 32'h010, 32'h0,        32'h000000EF, 1'b0});
        v.push_back('{1'b0, F3_B,  32'h013, 32'h0,        32'hFFFFFFDE, 1'b0});
        v.push_back('{1'b1, F3_W,  32'h020, 32'h0,        32'h0,        1'b0});
        v.push_back('{1'b1, F3_H,  32'h022, 32'h00008001, 32'h0,        1'b0});
        v.push_back('{1'b0, F3_W,  32'h020, 32'h0,        32'h80010000, 1'b0});
        v.push_back('{1'b0, F3_H,  32'h022, 32'h0,        32'hFFFF8001, 1'b0});
        v.push_back('{1'b0, F3_HU, 32'h022, 32'h0,        32'h00008001, 1'b0});
        v.push_back('{1'b0, F3_W,  32'h011, 32'h0,        32'h0,        1'b1});
        v.push_back('{1'b1, F3_H,  32'h023, 32'h00001234, 32'h0,        1'b1});
        v.push_back('{1'b0, F3_W,  32'h020, 32'h0,        32'h80010000, 1'b0});
        v.push_back('{1'b1, F3_W,  32'h000, 32'h0,        32'h0,        1'b0});
        v.push_back('{1'b1, F3_W,  32'h400, 32'hFFFFFFFF, 32'h0,        1'b1});
        v.push_back('{1'b1, F3_BU, 32'h000, 32'h000000FF, 32'h0,        1'b1});
        v.push_back('{1'b1, 3'b011,32'h000, 32'h000000FF, 32'h0,        1'b1});
        v.push_back('{1'b0, F3_W,  32'h000, 32'h0,        32'h0,        1'b0});
        v.push_back('{1'b0, F3_W,  32'h010, 32'h0,        32'hDEADBEEF, 1'b0});
        v.push_back('{1'b1, F3_B,  32'h021, 32'hAABBCC77, 32'h0,        1'b0});
        v.push_back('{1'b0, F3_W,  32'h020, 32'h0,        32'h80017700, 1'b0});
        v.push_back('{1'b0, F3_B,  32'h021, 32'h0,        32'h00000077, 1'b0});
        v.push_back('{1'b0, F3_B,  32'h023, 32'h0,        32'hFFFFFF80, 1'b0});
        v.push_back('{1'b0, 3'b110,32'h020, 32'h0,        32'h0,        1'b1});
        v.push_back('{1'b1, F3_W,  32'h3FC, 32'h12345678, 32'h0,        1'b0});
        v.push_back('{1'b0, F3_W,  32'h3FC, 32'h0,        32'h12345678, 1'b0});
        v.push_back('{1'b0, F3_B,  32'h3FF, 32'h0,        32'h00000012, 1'b0});
        v.push_back('{1'b0, F3_H,  32'h3FE, 32'h0,        32'h00001234, 1'b0});
        v.push_back('{1'b0, F3_H,  32'h3FF, 32'h0,        32'h0,        1'b1});
        v.push_back('{1'b0, F3_B,  32'h400, 32'h0,        32'h0,        1'b1});
        v.push_back('{1'b0, F3_W,  32'h80000010, 32'h0,   32'h0,        1'b1});

        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", {31'b0, req_ready[0]}, 32'd0);
        chk("reset rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
        chk("reset rsp_rdata", rsp_rdata[0], 32'd0);
        chk("reset rsp_err", {31'b0, rsp_err[0]}, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready after reset", {31'b0, req_ready[0]}, 32'd1);
        @(posedge clk); #1;

        foreach (v[i]) begin
            op(0, v[i].we, v[i].f3, v[i].addr, v[i].wd, rd, er);
            chk($sformatf("vec%0d rdata", i), rd, v[i].rd);
            chk($sformatf("vec%0d err", i), {31'b0, er}, {31'b0, v[i].er});
        end

        // Back-to-back loads with req_valid held high: one accept every two cycles
        b2b_addr = '{32'h010, 32'h020, 32'h3FC};
        b2b_exp  = '{32'hDEADBEEF, 32'h80017700, 32'h12345678};
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_funct3[0] = F3_W;
        for (int i = 0; i < 3; i++) begin
            req_addr[0] = b2b_addr[i];
            chk($sformatf("b2b%0d req_ready", i), {31'b0, req_ready[0]}, 32'd1);
            @(posedge clk); #1;
            chk($sformatf("b2b%0d rsp_valid", i), {31'b0, rsp_valid[0]}, 32'd1);
            chk($sformatf("b2b%0d busy", i), {31'b0, req_ready[0]}, 32'd0);
            chk($sformatf("b2b%0d rdata", i), rsp_rdata[0], b2b_exp[i]);
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b0;
        chk("b2b drained", {31'b0, rsp_valid[0]}, 32'd0);

        // Three wait states with a stalled consumer
        op(1, 1'b1, F3_W, 32'h040, 32'hCAFEF00D, rd, er);
        chk("ws3 store err", {31'b0, er}, 32'd0);
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = F3_W; req_addr[1] = 32'h040;
        chk("ws3 ready idle", {31'b0, req_ready[1]}, 32'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0; req_addr[1] = 32'h044;
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("ws3 cyc%0d rsp_valid", k), {31'b0, rsp_valid[1]}, 32'd0);
            chk($sformatf("ws3 cyc%0d req_ready", k), {31'b0, req_ready[1]}, 32'd0);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("ws3 hold%0d rsp_valid", k), {31'b0, rsp_valid[1]}, 32'd1);
            chk($sformatf("ws3 hold%0d rdata", k), rsp_rdata[1], 32'hCAFEF00D);
            chk($sformatf("ws3 hold%0d err", k), {31'b0, rsp_err[1]}, 32'd0);
            chk($sformatf("ws3 hold%0d req_ready", k), {31'b0, req_ready[1]}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready[1] = 1'b1;
        chk("ws3 last rsp_valid", {31'b0, rsp_valid[1]}, 32'd1);
        @(posedge clk); #1;
        chk("ws3 done rsp_valid", {31'b0, rsp_valid[1]}, 32'd0);
        chk("ws3 done req_ready", {31'b0, req_ready[1]}, 32'd1);

        // Reset while a store sits in ACCESS drops the store
        op(1, 1'b1, F3_W, 32'h044, 32'h11111111, rd, er);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = F3_W;
        req_addr[1] = 32'h044; req_wdata[1] = 32'h22222222;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst mid req_ready", {31'b0, req_ready[1]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst mid rsp_valid", {31'b0, rsp_valid[1]}, 32'd0);
        chk("rst mid req_ready after", {31'b0, req_ready[1]}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rst idle%0d rsp_valid", k), {31'b0, rsp_valid[1]}, 32'd0);
        end
        op(1, 1'b0, F3_W, 32'h044, 32'h0, rd, er);
        chk("rst dropped store", rd, 32'h11111111);
        chk("rst dropped err", {31'b0, er}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
